// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//   Press classifier for a debounced, already-synchronous button level.
//   Produces single-cycle event pulses: press, release, click (release before
//   the long threshold), long (threshold reached) and optional auto-repeat.
//
// Parameters
//   ACTIVE_LOW : 1 -> button is down when i_button == 0; 0 -> active high
//   LONG       : log2 of hold cycles before a long press (>= 1)
//   REPEAT     : log2 of auto-repeat period (1 <= REPEAT <= LONG)
//
// Ports
//   i_clock    : system clock, rising edge
//   i_reset    : synchronous active-high reset
//   i_button   : debounced button level
//   o_pressed  : registered level, 1 while the button is considered down
//   o_press    : pulse on idle-to-down
//   o_release  : pulse on down-to-idle
//   o_click    : pulse on a release before the long threshold
//   o_long     : pulse when the long threshold is reached
//   o_repeat   : pulse every 2^REPEAT cycles after o_long while still held
//
// Build option
//   BUTTON_EVENTS_REPEAT_EN : when defined, auto-repeat is enabled; otherwise
//   o_repeat stays 0 and the counter is frozen while held.
// -----------------------------------------------------------------------------
module button_events #(
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned LONG       = 20,
    parameter int unsigned REPEAT     = 18
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_button,
    output logic o_pressed,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_long,
    output logic o_repeat
);

`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LONG-1:0] r_cnt;
    logic [LONG-1:0] w_cnt_nxt;

    logic w_act;
    logic w_press;
    logic w_release;
    logic w_click;
    logic w_long;
    logic w_repeat;

    logic r_pressed;
    logic r_press;
    logic r_release;
    logic r_click;
    logic r_long;
    logic r_repeat;

    // Normalised "down" level regardless of input polarity.
    assign w_act = i_button ^ (ACTIVE_LOW != 0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_click     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_act) begin
                    w_state_nxt = SHORT;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                end
            end

            SHORT: begin
                // Release is tested first so it wins over the threshold.
                if (!w_act) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                    w_click     = 1'b1;
                end else if (&r_cnt) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LONG'(1);
                end
            end

            HELD: begin
                if (!w_act) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else if (REPEAT_EN) begin
                    // Counter wraps freely; only its low REPEAT bits set
                    // the repeat cadence.
                    w_cnt_nxt = r_cnt + LONG'(1);
                    if (&r_cnt[REPEAT-1:0]) begin
                        w_repeat = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pressed <= (w_state_nxt != IDLE);
            r_press   <= w_press;
            r_release <= w_release;
            r_click   <= w_click;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
        end
    end

    assign o_pressed = r_pressed;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_click   = r_click;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;

endmodule
